// File: rtl/spawn_pkg.sv
// Shared types and helpers for the obstacle spawn scheduler: FSM encoding,
// per-type minimum speed table and ring index arithmetic.
package spawn_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_SPAWN   = 3'd2;
    localparam state_t ST_SETTLE  = 3'd3;
    localparam state_t ST_RETIRE  = 3'd4;
    localparam state_t ST_CRASHED = 3'd5;

    localparam int unsigned TYPE_NONE = 0;
    localparam int unsigned MAX_TYPES = 15;

    // Index 0 is TYPE_NONE; type 2 needs moderate speed, type 3 (flyer) high speed.
    localparam int unsigned MIN_SPEED [MAX_TYPES+1] = '{
        0, 0, 4000, 8500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0
    };

    function automatic int unsigned min_speed(input int unsigned t);
        logic [3:0] idx;
        idx = t[3:0];
        return (t <= MAX_TYPES) ? MIN_SPEED[idx] : 0;
    endfunction

    function automatic int unsigned incr(input int unsigned p, input int unsigned n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

    function automatic int unsigned decr(input int unsigned p, input int unsigned n);
        return (p == 0) ? n - 1 : p - 1;
    endfunction

endpackage

// File: rtl/spawn_type_picker.sv
// Combinational obstacle type selection: walks the candidates starting at
// rng_data, skipping types too fast for the current speed or that would extend a run.
module spawn_type_picker
    import spawn_pkg::*;
#(
    parameter int TYPES   = 3,
    parameter int MAX_DUP = 2,
    parameter int SPEEDW  = 15,
    parameter int RNGW    = 11,
    parameter int TW      = $clog2(TYPES + 1)
) (
    input  logic [RNGW-1:0]              rng_data,
    input  logic [SPEEDW-1:0]            speed,
    input  logic [MAX_DUP-1:0][TW-1:0]   history,
    output logic [TW-1:0]                pick_type,
    output logic                         pick_valid
);

    function automatic logic [TW-1:0] cand_type(input logic [RNGW-1:0] rng, input int unsigned i);
        int unsigned r;
        r = 32'(rng);
        return TW'(((r + i) % TYPES) + 1);
    endfunction

    function automatic logic type_legal(input logic [TW-1:0] t,
                                        input logic [SPEEDW-1:0] spd,
                                        input logic [MAX_DUP-1:0][TW-1:0] hist);
        logic all_dup;
        all_dup = 1'b1;
        for (int j = 0; j < MAX_DUP; j++) begin
            if (hist[j] != t) all_dup = 1'b0;
        end
        return (32'(spd) >= min_speed(32'(t))) && !all_dup;
    endfunction

    always_comb begin
        pick_type  = TW'(TYPE_NONE);
        pick_valid = 1'b0;
        for (int i = 0; i < TYPES; i++) begin
            if (!pick_valid && type_legal(cand_type(rng_data, i), speed, history)) begin
                pick_valid = 1'b1;
                pick_type  = cand_type(rng_data, i);
            end
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Ring-buffer scheduler for scrolling obstacles: spawns into the back slot,
// pulses the per-frame update and retires scrolled-off slots from the front.
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int SLOTS   = 7,
    parameter int TYPES   = 3,
    parameter int MAX_DUP = 2,
    parameter int SPAWN_X = 600,
    parameter int XW      = 11,
    parameter int SPEEDW  = 15,
    parameter int RNGW    = 11,
    localparam int TW     = $clog2(TYPES + 1),
    localparam int CW     = $clog2(SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  crash,
    input  logic                  restart,
    input  logic                  update,
    input  logic                  spawn_en,
    input  logic [SPEEDW-1:0]     speed,
    input  logic [RNGW-1:0]       rng_data,
    input  logic [SLOTS-1:0]      slot_remove,
    input  logic [SLOTS-1:0]      slot_visible,
    input  logic [SLOTS*XW-1:0]   slot_x_pos,
    input  logic [SLOTS*10-1:0]   slot_width,
    input  logic [SLOTS*11-1:0]   slot_gap,
    output logic                  slot_update,
    output logic [SLOTS-1:0]      slot_start,
    output logic [SLOTS*TW-1:0]   slot_type,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  spawn_reject
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SW = XW + 2;
    localparam logic signed [SW-1:0] SPAWN_LIM = SW'(SPAWN_X);

    state_t                      state_q, state_d;
    logic [PW-1:0]               front_q, front_d;
    logic [PW-1:0]               back_q, back_d;
    logic [CW-1:0]               count_q, count_d;
    logic [SLOTS-1:0]            slot_start_q, slot_start_d;
    logic [TW-1:0]               slot_type_q [SLOTS];
    logic [TW-1:0]               slot_type_d [SLOTS];
    logic [MAX_DUP-1:0][TW-1:0]  hist_q, hist_d;
    logic                        spawn_reject_q, spawn_reject_d;

    logic [PW-1:0]               last_idx, back_nx, front_nx;
    logic signed [XW-1:0]        x_last;
    logic [9:0]                  w_last;
    logic [10:0]                 g_last;
    logic signed [SW-1:0]        reach;
    logic                        spawn_due, retire_now, retire_more;
    logic [TW-1:0]               pick_type;
    logic                        pick_valid;

    spawn_type_picker #(
        .TYPES   (TYPES),
        .MAX_DUP (MAX_DUP),
        .SPEEDW  (SPEEDW),
        .RNGW    (RNGW),
        .TW      (TW)
    ) u_picker (
        .rng_data   (rng_data),
        .speed      (speed),
        .history    (hist_q),
        .pick_type  (pick_type),
        .pick_valid (pick_valid)
    );

    assign last_idx = PW'(decr(32'(back_q), SLOTS));
    assign back_nx  = PW'(incr(32'(back_q), SLOTS));
    assign front_nx = PW'(incr(32'(front_q), SLOTS));

    assign x_last = slot_x_pos[32'(last_idx)*XW +: XW];
    assign w_last = slot_width[32'(last_idx)*10 +: 10];
    assign g_last = slot_gap[32'(last_idx)*11 +: 11];

    // Two guard bits keep x+width+gap from wrapping before the signed compare.
    assign reach = {{2{x_last[XW-1]}}, x_last}
                 + {{(SW-10){1'b0}}, w_last}
                 + {{(SW-11){1'b0}}, g_last};

    assign spawn_due   = (count_q == '0) || (slot_visible[last_idx] && (reach < SPAWN_LIM));
    assign retire_now  = (count_q != '0) && slot_remove[front_q];
    assign retire_more = (count_q > CW'(1)) && slot_remove[front_nx];

    always_comb begin
        state_d        = state_q;
        front_d        = front_q;
        back_d         = back_q;
        count_d        = count_q;
        slot_start_d   = slot_start_q;
        slot_type_d    = slot_type_q;
        hist_d         = hist_q;
        spawn_reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (crash)       state_d = ST_CRASHED;
                else if (update) state_d = ST_SPAWN;
            end
            ST_SPAWN: begin
                if (spawn_due && spawn_en) begin
                    if (!full && pick_valid) begin
                        slot_type_d[back_q]  = pick_type;
                        slot_start_d[back_q] = 1'b1;
                        back_d               = back_nx;
                        count_d              = count_q + CW'(1);
                        for (int j = MAX_DUP - 1; j > 0; j--) begin
                            hist_d[j] = hist_q[j-1];
                        end
                        hist_d[0] = pick_type;
                    end else begin
                        spawn_reject_d = 1'b1;
                    end
                end
                state_d = crash ? ST_CRASHED : ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = crash ? ST_CRASHED : ST_RETIRE;
            end
            ST_RETIRE: begin
                if (retire_now) begin
                    slot_start_d[front_q] = 1'b0;
                    slot_type_d[front_q]  = TW'(TYPE_NONE);
                    front_d               = front_nx;
                    count_d               = count_q - CW'(1);
                end
                // Look ahead one slot so a k-slot retire takes exactly k cycles.
                if (crash)                             state_d = ST_CRASHED;
                else if (!(retire_now && retire_more)) state_d = ST_RUN;
            end
            ST_CRASHED: begin
                state_d = ST_CRASHED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state_q        <= ST_IDLE;
            front_q        <= '0;
            back_q         <= '0;
            count_q        <= '0;
            slot_start_q   <= '0;
            slot_type_q    <= '{default: '0};
            hist_q         <= '0;
            spawn_reject_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            front_q        <= front_d;
            back_q         <= back_d;
            count_q        <= count_d;
            slot_start_q   <= slot_start_d;
            slot_type_q    <= slot_type_d;
            hist_q         <= hist_d;
            spawn_reject_q <= spawn_reject_d;
        end
    end

    always_comb begin
        slot_type = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_type[i*TW +: TW] = slot_type_q[i];
        end
    end

    assign slot_update  = (state_q == ST_SPAWN);
    assign slot_start   = slot_start_q;
    assign count        = count_q;
    assign full         = (count_q == CW'(SLOTS));
    assign spawn_reject = spawn_reject_q;

endmodule
